// File: rtl/data_out_uart_pkg.sv
// ---------------------------------------------------------------------------
// data_out_uart_pkg
//
// Shared types and constants for the data_out_uart serial output stage.
//   tx_state_e       : transmitter FSM states; PARITY is only reachable when
//                      DATA_OUT_UART_PARITY_EN is defined.
//   FRAME_DATA_BITS  : payload bits per UART frame.
//   evenParity()     : even-parity bit for a payload byte.
// ---------------------------------------------------------------------------
package data_out_uart_pkg;

    localparam int FRAME_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic evenParity(input logic [FRAME_DATA_BITS-1:0] payload);
        return ^payload;
    endfunction

endpackage

// File: rtl/data_out_uart_byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
//
// Circular byte FIFO used by data_out_uart. Never stalls the writer: a push
// into a full FIFO without a simultaneous pop is discarded and reported on
// o_dropped for one cycle. A push and a pop in the same cycle are both
// performed, even when full, leaving the occupancy unchanged.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_push     write request
//   i_pop      read request (ignored while empty)
//   i_data     byte to write
//   o_data     byte at the head of the FIFO (valid while o_empty is low)
//   o_count    number of stored bytes, 0..DEPTH
//   o_empty    FIFO holds no bytes
//   o_dropped  the current push request is being discarded
// ---------------------------------------------------------------------------
module byte_fifo #(
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic [7:0]           i_data,
    output logic [7:0]           o_data,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_empty,
    output logic                 o_dropped
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]           r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wrPtr;
    logic [PTR_W-1:0]     r_rdPtr;
    logic [CNT_WIDTH-1:0] r_count;

    logic w_full;
    logic w_doPush;
    logic w_doPop;

    // A full FIFO can still accept a byte when the head leaves in the same
    // cycle, so the push qualifier looks at the pop as well as at full.
    always_comb begin
        w_full    = (r_count == CNT_WIDTH'(DEPTH));
        o_empty   = (r_count == '0);
        w_doPop   = i_pop && !o_empty;
        w_doPush  = i_push && (!w_full || w_doPop);
        o_dropped = i_push && !w_doPush;
        o_data    = r_mem[r_rdPtr];
        o_count   = r_count;
    end

    // Storage needs no reset; only the pointers and count define contents.
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CNT_WIDTH'(1);
                2'b01:   r_count <= r_count - CNT_WIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/data_out_uart.sv
// ---------------------------------------------------------------------------
// data_out_uart
//
// Watches the core's result byte, queues every new value and shifts it out
// as an 8N1 UART frame (8E1 when DATA_OUT_UART_PARITY_EN is defined). The
// core is never stalled: changes arriving while the queue is full are lost
// and the sticky overflow flag is raised.
//
// Configuration macro: DATA_OUT_UART_PARITY_EN
//   defined   -> even-parity bit inserted between the data bits and stop bit
//   undefined -> plain 8N1 frame, no parity logic
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_i         asynchronous active-low reset
//   data_i        byte to monitor (core data_out_o)
//   tx_o          UART serial line, idles high
//   busy_o        high while a frame is being shifted
//   fifo_count_o  number of queued bytes, 0..FIFO_DEPTH
//   overflow_o    sticky flag, set when a detected change is dropped
// ---------------------------------------------------------------------------
module data_out_uart
    import data_out_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_WIDTH    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [7:0]           data_i,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] fifo_count_o,
    output logic                 overflow_o
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(FRAME_DATA_BITS);

    logic [7:0]                 r_prev;
    logic                       w_push;

    logic                       w_pop;
    logic [7:0]                 w_fifoData;
    logic                       w_fifoEmpty;
    logic                       w_dropped;

    tx_state_e                  r_state;
    tx_state_e                  w_stateNext;
    logic [BAUD_W-1:0]          r_baud;
    logic [BAUD_W-1:0]          w_baudNext;
    logic                       w_baudDone;
    logic [BIT_W-1:0]           r_bitIdx;
    logic [BIT_W-1:0]           w_bitIdxNext;
    logic [FRAME_DATA_BITS-1:0] r_shift;
    logic [FRAME_DATA_BITS-1:0] w_shiftNext;
    logic                       r_tx;
    logic                       w_txNext;
    logic                       r_overflow;
`ifdef DATA_OUT_UART_PARITY_EN
    logic                       r_parity;
    logic                       w_parityNext;
`endif

    // Any difference from the last seen value is a new result to queue.
    assign w_push = (data_i != r_prev);

    byte_fifo #(
        .DEPTH     (FIFO_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_fifo (
        .i_clk     (clk_i),
        .i_rst_n   (rst_i),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_data    (data_i),
        .o_data    (w_fifoData),
        .o_count   (fifo_count_o),
        .o_empty   (w_fifoEmpty),
        .o_dropped (w_dropped)
    );

    assign w_baudDone = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

    // Next-state logic. The line level is derived from the next state so that
    // tx_o comes straight from a flop and changes on the same edge as the
    // state, which keeps the pin glitch-free.
    always_comb begin
        w_stateNext  = r_state;
        w_baudNext   = r_baud + BAUD_W'(1);
        w_bitIdxNext = r_bitIdx;
        w_shiftNext  = r_shift;
        w_pop        = 1'b0;
        w_txNext     = 1'b1;
`ifdef DATA_OUT_UART_PARITY_EN
        w_parityNext = r_parity;
`endif

        case (r_state)
            IDLE: begin
                w_baudNext = '0;
                if (!w_fifoEmpty) begin
                    w_pop       = 1'b1;
                    w_shiftNext = w_fifoData;
                    w_stateNext = START;
`ifdef DATA_OUT_UART_PARITY_EN
                    w_parityNext = evenParity(w_fifoData);
`endif
                end
            end
            START: begin
                if (w_baudDone) begin
                    w_baudNext   = '0;
                    w_bitIdxNext = '0;
                    w_stateNext  = DATA;
                end
            end
            DATA: begin
                if (w_baudDone) begin
                    w_baudNext = '0;
                    if (r_bitIdx == BIT_W'(FRAME_DATA_BITS - 1)) begin
`ifdef DATA_OUT_UART_PARITY_EN
                        w_stateNext = PARITY;
`else
                        w_stateNext = STOP;
`endif
                    end else begin
                        w_bitIdxNext = r_bitIdx + BIT_W'(1);
                        w_shiftNext  = r_shift >> 1;
                    end
                end
            end
`ifdef DATA_OUT_UART_PARITY_EN
            PARITY: begin
                if (w_baudDone) begin
                    w_baudNext  = '0;
                    w_stateNext = STOP;
                end
            end
`endif
            STOP: begin
                if (w_baudDone) begin
                    w_baudNext  = '0;
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_baudNext  = '0;
                w_stateNext = IDLE;
            end
        endcase

        // The shift register is consumed LSB first, so bit 0 is always the
        // data bit currently on the line.
        case (w_stateNext)
            START:   w_txNext = 1'b0;
            DATA:    w_txNext = w_shiftNext[0];
`ifdef DATA_OUT_UART_PARITY_EN
            PARITY:  w_txNext = w_parityNext;
`endif
            default: w_txNext = 1'b1;
        endcase
    end

    // State, baud counter and line register; reset abandons any frame and
    // returns the line high at once.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_prev     <= '0;
            r_state    <= IDLE;
            r_baud     <= '0;
            r_bitIdx   <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_overflow <= 1'b0;
`ifdef DATA_OUT_UART_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_prev     <= data_i;
            r_state    <= w_stateNext;
            r_baud     <= w_baudNext;
            r_bitIdx   <= w_bitIdxNext;
            r_shift    <= w_shiftNext;
            r_tx       <= w_txNext;
            if (w_dropped) begin
                r_overflow <= 1'b1;
            end
`ifdef DATA_OUT_UART_PARITY_EN
            r_parity   <= w_parityNext;
`endif
        end
    end

    assign tx_o       = r_tx;
    assign busy_o     = (r_state != IDLE);
    assign overflow_o = r_overflow;

endmodule

// File: doc/data_out_uart.md
# data_out_uart

Serial output stage downstream of the `riscv` core's 8-bit `data_out_o` (low byte of `a0`). The block detects every change of that byte, queues the new value in a small FIFO and shifts it out as an 8N1 UART frame, so program results can be observed on one pin without stalling the core. It never back-pressures the core: values arriving while the FIFO is full are dropped and flagged.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (115200 baud at 100 MHz); legal range ≥ 2.
- `FIFO_DEPTH`, default 8: entries in the byte FIFO; power of two, ≥ 2.
- `CNT_WIDTH`, default `$clog2(FIFO_DEPTH)+1`: width of `fifo_count_o`.

Ports:
- `clk_i`  in  1  single system clock, rising-edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `data_i`  in  8  byte to monitor; connect to the core's `data_out_o`.
- `tx_o`  out  1  UART serial line; idles high.
- `busy_o`  out  1  high while a frame is being shifted.
- `fifo_count_o`  out  CNT_WIDTH  number of queued bytes, 0..FIFO_DEPTH.
- `overflow_o`  out  1  sticky; set when a detected change is dropped.

## Operation
- Change detect: register `prev_q` (reset 0). In any cycle where `data_i != prev_q`, a push request is raised and `prev_q <= data_i`. A steady nonzero value after reset produces exactly one push.
- FIFO: circular buffer with read/write pointers of `$clog2(FIFO_DEPTH)` bits that wrap naturally, plus an occupancy counter.
  - Push when full and no pop in the same cycle: byte dropped, `overflow_o <= 1`, cleared only by reset.
  - Push and pop in the same cycle: both performed, count unchanged; this holds when full.
  - Pop only when not empty.
- TX FSM states: IDLE, START, DATA, STOP (plus PARITY under the macro).
  - IDLE: `tx_o`=1. If FIFO not empty, pop into `shift_q`, go to START.
  - START: `tx_o`=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles; bit index 0..7.
  - STOP: `tx_o`=1 for CLKS_PER_BIT cycles, then IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and reloads at each state or bit change.
- `busy_o` = (state != IDLE).

## Timing
- Reset (asynchronous, any time including mid-frame):
  - `tx_o`=1, `busy_o`=0, `fifo_count_o`=0, `overflow_o`=0.
  - FSM to IDLE; `prev_q`, pointers and counters cleared.
  - Any partial frame is abandoned; the line returns high immediately.
- A change seen at edge N is pushed at edge N, and `fifo_count_o` reflects it after N.
- When the FIFO is non-empty in IDLE at edge M, the pop occurs at M. `tx_o` falls after M, so latency from a change on `data_i` to the start bit on an idle, empty block is 2 edges.
- Frame length: 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- Back-to-back frames: STOP exits to IDLE, and the next pop happens on the following edge. That gives exactly one IDLE cycle (`tx_o`=1) between frames.
- `data_i` toggling every cycle pushes every cycle; the FIFO fills and then overflows.

## Configuration
- Macro `DATA_OUT_UART_PARITY_EN`.
  - Defined: a PARITY state is inserted between DATA and STOP. It drives an even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, giving an 8E1 frame.
  - Undefined: 8N1, and no PARITY state or logic exists.

## Structure
- Package `data_out_uart_pkg`: typedef `tx_state_e` enum (IDLE, START, DATA, PARITY, STOP) and the `FRAME_DATA_BITS`=8 constant.
- Sub-module `byte_fifo` holds the storage, pointers, count, full/empty and simultaneous push/pop handling. The top contains change detect, the FSM, the baud counter and the overflow flag.

## Test plan
Benches use CLKS_PER_BIT=4, FIFO_DEPTH=4.
- Reset, hold `data_i`=0 for 100 cycles -> `tx_o` stays 1, `fifo_count_o`=0, `busy_o`=0.
- `data_i` 0→0xA5 and hold -> one frame on `tx_o`: start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 4 cycles. The start bit appears 2 edges after the change, and `busy_o` is high for exactly 40 cycles.
- `data_i` = 0x01,0x02,0x03,0x04,0x05,0x06 on consecutive cycles -> the first byte is popped at once and the next 4 fill the FIFO. The 6th is dropped, so `overflow_o`=1 and persists, and frames 0x01..0x05 are emitted with 1 idle cycle between them.
- Same byte re-written (0x3C, then 0x3C) -> exactly one frame.
- Assert `rst_i` low mid-DATA of a 0xFF frame -> `tx_o`=1 and `busy_o`=0 immediately, count 0. After release with `data_i` still 0xFF, one new 0xFF frame is sent.
- With `DATA_OUT_UART_PARITY_EN`, send 0x07 -> parity bit 1 and frame length 44 cycles. Sending 0x03 gives parity bit 0.
